// File: rtl/lift_step_pipe.sv
// lift_step_pipe: two-stage pipelined 5/3 lifting step (predict/update, forward/inverse).
//
// LANES independent datapaths share one flag set and one valid/ready handshake.
// Stage 1 registers s = left + right (DW+1 bits), the centre sample and the flags.
// Stage 2 registers the lifting result and drives res_o / out_valid_o.
//
// Optional feature macro: LIFT_SAT_EN
//   defined   - each lane result is clamped to the DW-bit signed range, and sat_o is
//               sticky-set whenever a clamped result loads into stage 2
//   undefined - full-precision results, sat_o tied to 0
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   flags_i      [2] active, [1] 1=predict/0=update, [0] 1=forward/0=inverse
//   in_valid_i   input beat valid
//   in_ready_o   input beat can be accepted this cycle
//   left_i       left neighbour samples, lane k = [k*DW +: DW]
//   sam_i        centre samples
//   right_i      right neighbour samples
//   out_valid_o  res_o holds a result
//   out_ready_i  downstream accepts the result
//   res_o        signed results, lane k = [k*OW +: OW]
//   sat_o        sticky saturation flag
module lift_step_pipe #(
    parameter int unsigned DW    = 9,
    parameter int unsigned LANES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [2:0]            flags_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES*DW-1:0]   left_i,
    input  logic [LANES*DW-1:0]   sam_i,
    input  logic [LANES*DW-1:0]   right_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*(DW+1)-1:0] res_o,
    output logic                  sat_o
);

    localparam int unsigned OW = DW + 1;  // result width
    localparam int unsigned SW = DW + 1;  // neighbour-sum width
    localparam int unsigned XW = OW + 1;  // working width before range handling

    localparam logic signed [XW-1:0] RoundTwo = XW'(2);

    // Stage registers
    logic                    s1_valid_q;
    logic [LANES*SW-1:0]     s1_sum_q;
    logic [LANES*DW-1:0]     s1_sam_q;
    logic [2:0]              s1_flags_q;
    logic                    s2_valid_q;
    logic [LANES*OW-1:0]     res_q;

    // Handshake / advance control
    logic s2_adv;
    logic s2_load;
    logic s1_load;

    // S2 drains or is empty -> it can take whatever S1 holds.
    assign s2_adv     = !s2_valid_q || out_ready_i;
    assign s2_load    = s1_valid_q && s2_adv;
    assign in_ready_o = !s1_valid_q || s2_adv;
    assign s1_load    = in_valid_i && in_ready_o;

    // Stage 1 combinational: sign-extended neighbour sum per lane
    logic [LANES*SW-1:0] sum_d;

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_d[k*SW +: SW] = {left_i[k*DW + DW - 1], left_i[k*DW +: DW]}
                              + {right_i[k*DW + DW - 1], right_i[k*DW +: DW]};
        end
    end

    // Stage 2 combinational: lifting arithmetic per lane
    logic [LANES*OW-1:0]     res_d;
    logic signed [XW-1:0]    sam_x;
    logic signed [XW-1:0]    sum_x;
    logic signed [XW-1:0]    half;
    logic signed [XW-1:0]    quarter;
    logic signed [XW-1:0]    full;
`ifdef LIFT_SAT_EN
    logic signed [XW-1:0]    sat_max;
    logic signed [XW-1:0]    sat_min;
    logic                    clip_any;
`endif

    always_comb begin
        res_d   = '0;
        sam_x   = '0;
        sum_x   = '0;
        half    = '0;
        quarter = '0;
        full    = '0;
`ifdef LIFT_SAT_EN
        // +2^(DW-1)-1 and -2^(DW-1) at working width
        sat_max          = '0;
        sat_max[DW-2:0]  = '1;
        sat_min          = '1;
        sat_min[DW-2:0]  = '0;
        clip_any         = 1'b0;
`endif
        for (int k = 0; k < LANES; k++) begin
            sam_x   = {{(XW-DW){s1_sam_q[k*DW + DW - 1]}}, s1_sam_q[k*DW +: DW]};
            sum_x   = {{(XW-SW){s1_sum_q[k*SW + SW - 1]}}, s1_sum_q[k*SW +: SW]};
            half    = sum_x >>> 1;
            quarter = (sum_x + RoundTwo) >>> 2;
            if (!s1_flags_q[2]) begin
                full = sam_x;
            end else begin
                unique case (s1_flags_q[1:0])
                    2'b11:   full = sam_x - half;     // forward predict
                    2'b10:   full = sam_x + half;     // inverse predict
                    2'b01:   full = sam_x + quarter;  // forward update
                    default: full = sam_x - quarter;  // inverse update
                endcase
            end
`ifdef LIFT_SAT_EN
            if (full > sat_max) begin
                full     = sat_max;
                clip_any = 1'b1;
            end else if (full < sat_min) begin
                full     = sat_min;
                clip_any = 1'b1;
            end
`endif
            // Full-precision results always fit OW bits, so dropping the top bit is lossless.
            res_d[k*OW +: OW] = full[OW-1:0];
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_sam_q   <= '0;
            s1_flags_q <= '0;
        end else begin
            if (in_ready_o) begin
                s1_valid_q <= in_valid_i;
            end
            if (s1_load) begin
                s1_sum_q   <= sum_d;
                s1_sam_q   <= sam_i;
                s1_flags_q <= flags_i;
            end
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s2_load) begin
                res_q <= res_d;
            end
        end
    end

`ifdef LIFT_SAT_EN
    logic sat_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sat_q <= 1'b0;
        end else if (s2_load && clip_any) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

    assign out_valid_o = s2_valid_q;
    assign res_o       = res_q;

endmodule

// File: tb/tb_lift_step_pipe.sv
// Directed testbench for lift_step_pipe: one single-lane and one two-lane instance.
module tb_lift_step_pipe;

`ifdef LIFT_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Single-lane instance
    logic [2:0]  flags;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  left;
    logic [8:0]  sam;
    logic [8:0]  right;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  res;
    logic        sat;

    // Two-lane instance
    logic [2:0]  flags2;
    logic        in_valid2;
    logic        in_ready2;
    logic [17:0] left2;
    logic [17:0] sam2;
    logic [17:0] right2;
    logic        out_valid2;
    logic        out_ready2;
    logic [19:0] res2;
    logic        sat2;

    int chk_cnt = 0;
    int err_cnt = 0;
    int exp_sat = 0;

    lift_step_pipe #(.DW(9), .LANES(1)) u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flags_i     (flags),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .left_i      (left),
        .sam_i       (sam),
        .right_i     (right),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .sat_o       (sat)
    );

    lift_step_pipe #(.DW(9), .LANES(2)) u_dut2 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flags_i     (flags2),
        .in_valid_i  (in_valid2),
        .in_ready_o  (in_ready2),
        .left_i      (left2),
        .sam_i       (sam2),
        .right_i     (right2),
        .out_valid_o (out_valid2),
        .out_ready_i (out_ready2),
        .res_o       (res2),
        .sat_o       (sat2)
    );

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sres(input logic [9:0] v);
        return int'($signed(v));
    endfunction

    task automatic drive(input int l, input int r, input int s, input logic [2:0] f);
        left     = l[8:0];
        right    = r[8:0];
        sam      = s[8:0];
        flags    = f;
        in_valid = 1'b1;
    endtask

    // Single beat through an idle pipe: result visible after the edge following acceptance.
    task automatic one_beat(input string tag, input int l, input int r, input int s,
                            input logic [2:0] f, input int exp);
        @(negedge clk);
        drive(l, r, s, f);
        check({tag, "_rdy"}, int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_s1"}, int'(out_valid), 0);
        @(negedge clk);
        check({tag, "_vld"}, int'(out_valid), 1);
        check(tag, sres(res), exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        flags      = '0;
        in_valid   = 1'b0;
        left       = '0;
        sam        = '0;
        right      = '0;
        out_ready  = 1'b1;
        flags2     = '0;
        in_valid2  = 1'b0;
        left2      = '0;
        sam2       = '0;
        right2     = '0;
        out_ready2 = 1'b1;

        #3;
        check("rst_vld", int'(out_valid), 0);
        check("rst_res", sres(res), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_rdy", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // T1..T4 directed vectors
        one_beat("t1_fp", 68, 163, 218, 3'd7, 103);
        check("t1_sat", int'(sat), 0);
        one_beat("t2_fu", 68, 163, 231, 3'd5, SatEn ? 255 : 289);
        if (SatEn) exp_sat = 1;
        check("t2_sat", int'(sat), exp_sat);
        one_beat("t3_ip", 164, 160, 250, 3'd6, SatEn ? 255 : 412);
        one_beat("t3_iu", 164, 160, 203, 3'd4, 122);
        one_beat("t3_floor", -3, 0, 0, 3'd7, 2);
        one_beat("t4_ip", -256, -256, -256, 3'd6, SatEn ? -256 : -512);
        check("t4_sat", int'(sat), exp_sat);
        one_beat("t4_byp", -256, -256, -256, 3'd3, -256);

        // T5 stall: three beats offered back-to-back with downstream blocked
        @(negedge clk);
        out_ready = 1'b0;
        drive(68, 163, 218, 3'd7);
        check("t5_rdy_a", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        drive(164, 160, 203, 3'd4);
        check("t5_rdy_b", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        drive(-3, 0, 0, 3'd7);
        check("t5_rdy_c", int'(in_ready), 0);
        check("t5_vld_a", int'(out_valid), 1);
        check("t5_res_a", sres(res), 103);
        @(posedge clk);
        @(negedge clk);
        check("t5_hold_rdy", int'(in_ready), 0);
        check("t5_hold_res", sres(res), 103);
        out_ready = 1'b1;
        #1;
        check("t5_rel_rdy", int'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t5_vld_b", int'(out_valid), 1);
        check("t5_res_b", sres(res), 122);
        @(negedge clk);
        check("t5_vld_c", int'(out_valid), 1);
        check("t5_res_c", sres(res), 2);
        @(negedge clk);
        check("t5_drain", int'(out_valid), 0);

        // T6 two lanes: lane0 = T1 data, lane1 = T3 data, forward predict
        @(negedge clk);
        left2     = {9'd164, 9'd68};
        right2    = {9'd160, 9'd163};
        sam2      = {9'd250, 9'd218};
        flags2    = 3'd7;
        in_valid2 = 1'b1;
        check("t6_rdy", int'(in_ready2), 1);
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        @(negedge clk);
        check("t6_s1", int'(out_valid2), 0);
        @(negedge clk);
        check("t6_vld", int'(out_valid2), 1);
        check("t6_lane0", sres(res2[9:0]), 103);
        check("t6_lane1", sres(res2[19:10]), 88);

        // T6 reset with two beats in flight
        @(negedge clk);
        drive(68, 163, 218, 3'd7);
        @(posedge clk);
        @(negedge clk);
        drive(164, 160, 203, 3'd4);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t6_full", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_vld", int'(out_valid), 0);
        check("t6_rst_res", sres(res), 0);
        check("t6_rst_rdy", int'(in_ready), 1);
        check("t6_rst_sat", int'(sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_vld", int'(out_valid), 0);
        @(negedge clk);
        check("t6_post_vld2", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
